// File: rtl/i2c_xfer_seq.sv
// i2c_xfer_seq: drives one complete I2C read or write transfer through an
// APB-attached I2C controller (enable, address byte, data bytes, bus idle wait),
// with a per-wait-state stall limit that falls back to a controller soft reset.
module i2c_xfer_seq #(
    parameter int          TIMEOUT = 4096,
    parameter logic [31:0] BASE    = 32'h0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rnw,
    input  logic [6:0]  cmd_addr,
    input  logic [3:0]  cmd_len,
    input  logic        wdat_valid,
    output logic        wdat_ready,
    input  logic [7:0]  wdat,
    output logic        rdat_valid,
    input  logic        rdat_ready,
    output logic [7:0]  rdat,
    output logic        done,
    output logic        err,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready
);

    localparam logic [31:0] OFF_CR     = 32'h100;
    localparam logic [31:0] OFF_SR     = 32'h104;
    localparam logic [31:0] OFF_TXFIFO = 32'h108;
    localparam logic [31:0] OFF_RXFIFO = 32'h10C;
    localparam logic [31:0] OFF_TXOCY  = 32'h114;
    localparam logic [31:0] OFF_RXOCY  = 32'h118;
    localparam logic [31:0] OFF_SRST   = 32'h040;

    localparam int            TW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE, S_EN, S_ADDR, S_WPOLL, S_WDATA, S_RCNT,
        S_RPOLL, S_RDATA, S_ROUT, S_BBPOLL, S_SRST, S_DONE
    } state_t;

    typedef enum logic [1:0] {AP_IDLE, AP_SETUP, AP_ACCESS} apb_t;

    state_t        state;
    apb_t          ap;
    logic [6:0]    addr_q;
    logic          rnw_q;
    logic [3:0]    len_q;
    logic [3:0]    rem;
    logic          eflag;
    logic [TW-1:0] tcnt;

    logic          acc_req;
    logic          acc_wr;
    logic [31:0]   acc_off;
    logic [31:0]   acc_dat;
    logic          counting;
    logic          timed_out;
    logic          unused_prdata;

    assign cmd_ready     = (state == S_IDLE);
    assign counting      = (state inside {S_WPOLL, S_WDATA, S_RPOLL, S_ROUT, S_BBPOLL});
    assign timed_out     = counting && (tcnt == TLIM) && (ap == AP_IDLE);
    assign unused_prdata = ^prdata[31:8];

    // Register access each state wants to launch; reads always carry zero write data
    always_comb begin
        acc_req = 1'b0;
        acc_wr  = 1'b0;
        acc_off = 32'h0;
        acc_dat = 32'h0;
        case (state)
            S_EN:     begin acc_req = 1'b1; acc_wr = 1'b1; acc_off = OFF_CR; acc_dat = 32'h1; end
            S_ADDR:   begin acc_req = 1'b1; acc_wr = 1'b1; acc_off = OFF_TXFIFO;
                            acc_dat = {22'b0, 1'b0, 1'b1, addr_q, rnw_q}; end
            S_WPOLL:  begin acc_req = 1'b1; acc_off = OFF_TXOCY; end
            S_WDATA:  begin acc_req = wdat_valid && wdat_ready; acc_wr = 1'b1; acc_off = OFF_TXFIFO;
                            acc_dat = {22'b0, (rem == 4'd1), 1'b0, wdat}; end
            S_RCNT:   begin acc_req = 1'b1; acc_wr = 1'b1; acc_off = OFF_TXFIFO;
                            acc_dat = {22'b0, 1'b1, 1'b0, 4'b0, len_q}; end
            S_RPOLL:  begin acc_req = 1'b1; acc_off = OFF_RXOCY; end
            S_RDATA:  begin acc_req = 1'b1; acc_off = OFF_RXFIFO; end
            S_BBPOLL: begin acc_req = 1'b1; acc_off = OFF_SR; end
            S_SRST:   begin acc_req = 1'b1; acc_wr = 1'b1; acc_off = OFF_SRST; acc_dat = 32'hA; end
            default:  ;
        endcase
    end

    // Transfer sequencer and APB engine; every state change clears the stall counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            ap         <= AP_IDLE;
            addr_q     <= 7'd0;
            rnw_q      <= 1'b0;
            len_q      <= 4'd0;
            rem        <= 4'd0;
            eflag      <= 1'b0;
            tcnt       <= '0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= 32'h0;
            pwdata     <= 32'h0;
            done       <= 1'b0;
            err        <= 1'b0;
            wdat_ready <= 1'b0;
            rdat_valid <= 1'b0;
            rdat       <= 8'h0;
        end else begin
            if (counting && tcnt != TLIM)
                tcnt <= tcnt + TW'(1);
            case (ap)
                AP_IDLE: begin
                    if (timed_out) begin
                        state      <= S_SRST;
                        tcnt       <= '0;
                        wdat_ready <= 1'b0;
                        rdat_valid <= 1'b0;
                    end else begin
                        if (acc_req) begin
                            psel    <= 1'b1;
                            penable <= 1'b0;
                            pwrite  <= acc_wr;
                            paddr   <= BASE + acc_off;
                            pwdata  <= acc_dat;
                            ap      <= AP_SETUP;
                        end
                        case (state)
                            S_IDLE: if (cmd_valid) begin
                                addr_q <= cmd_addr;
                                rnw_q  <= cmd_rnw;
                                len_q  <= cmd_len;
                                rem    <= cmd_len;
                                tcnt   <= '0;
                                eflag  <= (cmd_len == 4'd0);
                                state  <= (cmd_len == 4'd0) ? S_DONE : S_EN;
                            end
                            S_WDATA: wdat_ready <= !(wdat_valid && wdat_ready);
                            S_ROUT: if (rdat_valid && rdat_ready) begin
                                rdat_valid <= 1'b0;
                                if (rem != 4'd0) rem <= rem - 4'd1;
                                state <= (rem > 4'd1) ? S_RPOLL : S_BBPOLL;
                                tcnt  <= '0;
                            end
                            S_DONE: begin
                                if (!done) begin
                                    done <= 1'b1;
                                    err  <= eflag;
                                end else begin
                                    done  <= 1'b0;
                                    err   <= 1'b0;
                                    state <= S_IDLE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                AP_SETUP: begin
                    penable <= 1'b1;
                    ap      <= AP_ACCESS;
                end
                AP_ACCESS: if (pready) begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    ap      <= AP_IDLE;
                    case (state)
                        S_EN:   begin state <= S_ADDR; tcnt <= '0; end
                        S_ADDR: begin state <= rnw_q ? S_RCNT : S_WPOLL; tcnt <= '0; end
                        S_WPOLL: if (prdata[4:0] < 5'd16) begin
                            state <= S_WDATA;
                            tcnt  <= '0;
                        end
                        S_WDATA: begin
                            if (rem != 4'd0) rem <= rem - 4'd1;
                            state <= (rem > 4'd1) ? S_WPOLL : S_BBPOLL;
                            tcnt  <= '0;
                        end
                        S_RCNT: begin state <= S_RPOLL; tcnt <= '0; end
                        S_RPOLL: if (prdata[4:0] != 5'd0) begin
                            state <= S_RDATA;
                            tcnt  <= '0;
                        end
                        S_RDATA: begin
                            rdat       <= prdata[7:0];
                            rdat_valid <= 1'b1;
                            state      <= S_ROUT;
                            tcnt       <= '0;
                        end
                        S_BBPOLL: if (!prdata[2]) begin
                            eflag <= 1'b0;
                            state <= S_DONE;
                            tcnt  <= '0;
                        end
                        S_SRST: begin
                            eflag <= 1'b1;
                            state <= S_DONE;
                            tcnt  <= '0;
                        end
                        default: ;
                    endcase
                end
                default: ap <= AP_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// tb_i2c_xfer_seq: directed and randomized transfers against an APB controller
// model; expected register writes and data streams come from the transfer rules.
module tb_i2c_xfer_seq;

    localparam int          TMO    = 40;
    localparam logic [31:0] BASE_A = 32'h4000_0000;
    localparam int          BUDGET = 4000;

    logic        clk, rstn;
    logic        cmd_valid, cmd_ready, cmd_rnw;
    logic [6:0]  cmd_addr;
    logic [3:0]  cmd_len;
    logic        wdat_valid, wdat_ready;
    logic [7:0]  wdat;
    logic        rdat_valid, rdat_ready;
    logic [7:0]  rdat;
    logic        done, err;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready;

    i2c_xfer_seq #(.TIMEOUT(TMO), .BASE(BASE_A)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat),
        .rdat_valid(rdat_valid), .rdat_ready(rdat_ready), .rdat(rdat),
        .done(done), .err(err),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    // Transfer expectations and observations
    logic [63:0] exp_wr[$];
    logic [63:0] obs_wr[$];
    logic [7:0]  rx_src[$];
    logic [7:0]  rx_exp[$];
    logic [7:0]  rd_got[$];
    logic [7:0]  wq[$];
    logic [7:0]  preset[$];
    int fifo_reads, n_accept, n_access;

    // Controller model configuration and state
    int stall_mode = 0;
    int fixed_k    = 0;
    bit txocy_stuck = 0;
    int cur_stall, wait_cnt, poll_cnt, poll_k, en_cycles;
    bit ret_busy;
    logic [31:0] setup_addr;
    bit   hold_valid;
    logic [7:0] held;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Controller model and stream sources, driven away from the active edge
    initial begin
        logic [31:0] off, rnd;
        pready = 1'b0; prdata = 32'h0; wdat_valid = 1'b0; wdat = 8'h0; rdat_ready = 1'b0;
        forever begin
            @(negedge clk);
            rnd = $urandom;
            wdat_valid = (wq.size() > 0) && ($urandom_range(0, 3) != 0);
            wdat       = (wq.size() > 0) ? wq[0] : 8'h0;
            rdat_ready = ($urandom_range(0, 2) != 0);
            if (!rstn) begin
                pready = 1'b0;
            end else if (psel && !penable) begin
                cur_stall  = (stall_mode < 0) ? $urandom_range(0, 2) : stall_mode;
                wait_cnt   = 0;
                en_cycles  = 0;
                setup_addr = paddr;
                pready     = 1'b0;
            end else if (psel && penable) begin
                if (wait_cnt < cur_stall) begin
                    pready = 1'b0; prdata = rnd; wait_cnt++;
                end else begin
                    pready = 1'b1;
                    off = paddr - BASE_A;
                    ret_busy = 1'b0;
                    case (off)
                        32'h114: begin ret_busy = txocy_stuck || (poll_cnt < poll_k);
                                       prdata = ret_busy ? 32'h10 : 32'($urandom_range(0, 15)); end
                        32'h118: begin ret_busy = (poll_cnt < poll_k);
                                       prdata = ret_busy ? 32'h0 : 32'($urandom_range(1, 16)); end
                        32'h104: begin ret_busy = (poll_cnt < poll_k);
                                       prdata = ret_busy ? 32'h7 : 32'h3; end
                        32'h10C: prdata = {rnd[31:8], (rx_src.size() > 0) ? rx_src[0] : 8'hEE};
                        default: prdata = 32'h0;
                    endcase
                end
            end else begin
                pready = 1'b0; prdata = rnd;
            end
        end
    end

    // Observe APB completions, stream handshakes and command acceptances
    initial begin
        logic [31:0] off;
        hold_valid = 1'b0;
        forever begin
            @(posedge clk);
            if (!rstn) begin
                hold_valid = 1'b0;
            end else begin
                if (cmd_valid && cmd_ready) n_accept++;
                if (wdat_valid && wdat_ready && wq.size() > 0) void'(wq.pop_front());
                if (hold_valid && rdat_valid) checkOutput("rdat_stable", 64'(rdat), 64'(held));
                hold_valid = rdat_valid && !rdat_ready;
                held = rdat;
                if (rdat_valid && rdat_ready) rd_got.push_back(rdat);
                if (psel && penable) en_cycles++;
                if (psel && penable && pready) begin
                    n_access++;
                    checkOutput("penable_cycles", 64'(en_cycles), 64'(cur_stall + 1));
                    checkOutput("paddr_held", 64'(paddr), 64'(setup_addr));
                    off = paddr - BASE_A;
                    if (pwrite) begin
                        obs_wr.push_back({paddr, pwdata});
                    end else begin
                        checkOutput("pwdata_read_zero", 64'(pwdata), 64'h0);
                        if (off == 32'h10C) begin
                            fifo_reads++;
                            if (rx_src.size() > 0) void'(rx_src.pop_front());
                        end else if (ret_busy) begin
                            poll_cnt++;
                        end else begin
                            poll_cnt = 0;
                            poll_k = (fixed_k >= 0) ? fixed_k : $urandom_range(0, 2);
                        end
                    end
                end
            end
        end
    end

    task automatic prep(input logic rnw, input logic [6:0] a, input logic [3:0] len, input bit tmo);
        logic [7:0]  b;
        logic [31:0] aw;
        exp_wr.delete(); obs_wr.delete(); rx_src.delete(); rx_exp.delete(); rd_got.delete(); wq.delete();
        fifo_reads = 0; n_accept = 0; n_access = 0; poll_cnt = 0;
        poll_k = (fixed_k >= 0) ? fixed_k : $urandom_range(0, 2);
        if (len != 4'd0) begin
            aw = 32'h100 | (32'(a) << 1) | 32'(rnw);
            exp_wr.push_back({BASE_A + 32'h100, 32'h1});
            exp_wr.push_back({BASE_A + 32'h108, aw});
            if (tmo) begin
                exp_wr.push_back({BASE_A + 32'h040, 32'hA});
            end else if (rnw) begin
                exp_wr.push_back({BASE_A + 32'h108, 32'h200 | 32'(len)});
                for (int i = 0; i < int'(len); i++) begin
                    b = (preset.size() > 0) ? preset.pop_front() : 8'($urandom);
                    rx_src.push_back(b); rx_exp.push_back(b);
                end
            end else begin
                for (int i = 0; i < int'(len); i++) begin
                    b = (preset.size() > 0) ? preset.pop_front() : 8'($urandom);
                    wq.push_back(b);
                    exp_wr.push_back({BASE_A + 32'h108, ((i == int'(len) - 1) ? 32'h200 : 32'h0) | 32'(b)});
                end
            end
        end
        preset.delete();
    endtask

    task automatic applyStimulus(input logic rnw, input logic [6:0] a, input logic [3:0] len);
        @(negedge clk);
        checkOutput("cmd_ready_idle", 64'(cmd_ready), 64'h1);
        cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = a; cmd_len = len;
        @(posedge clk);
        @(negedge clk);
        checkOutput("cmd_ready_busy", 64'(cmd_ready), 64'h0);
    endtask

    // Wait for completion (cmd_valid held high throughout) and compare everything
    task automatic finishCmd(input bit exp_err, input int min_cyc, input int exp_lat, input bit no_apb);
        bit seen = 1'b0;
        int lat  = 0;
        logic got_err = 1'b0;
        for (int c = 1; c <= BUDGET; c++) begin
            if (c > 1) @(negedge clk);
            if (done === 1'b1) begin seen = 1'b1; lat = c; got_err = err; break; end
        end
        cmd_valid = 1'b0;
        checkOutput("done_seen", 64'(seen), 64'h1);
        checkOutput("err", 64'(got_err), 64'(exp_err));
        if (exp_lat >= 0) checkOutput("done_latency", 64'(lat), 64'(exp_lat));
        if (min_cyc > 0)  checkOutput("timeout_min_cycles", 64'(lat >= min_cyc), 64'h1);
        @(negedge clk);
        checkOutput("done_one_cycle", 64'(done), 64'h0);
        checkOutput("single_accept", 64'(n_accept), 64'h1);
        if (no_apb) checkOutput("no_apb_access", 64'(n_access), 64'h0);
        checkOutput("write_count", 64'(obs_wr.size()), 64'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
            checkOutput("write_word", obs_wr[i], exp_wr[i]);
        checkOutput("rxfifo_reads", 64'(fifo_reads), 64'(rx_exp.size()));
        checkOutput("rdat_count", 64'(rd_got.size()), 64'(rx_exp.size()));
        for (int i = 0; i < rx_exp.size() && i < rd_got.size(); i++)
            checkOutput("rdat_value", 64'(rd_got[i]), 64'(rx_exp[i]));
        checkOutput("wdat_consumed", 64'(wq.size()), 64'h0);
    endtask

    task automatic run_cmd(input logic rnw, input logic [6:0] a, input logic [3:0] len,
                           input bit tmo, input int exp_lat);
        prep(rnw, a, len, tmo);
        applyStimulus(rnw, a, len);
        finishCmd(tmo || (len == 4'd0), tmo ? TMO : 0, exp_lat, (len == 4'd0));
    endtask

    initial begin
        bit found;
        rstn = 1'b0; cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = 7'h0; cmd_len = 4'h0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ctrl", {psel, penable, pwrite, done, err, rdat_valid, wdat_ready, cmd_ready}, 8'h01);
        checkOutput("reset_paddr", 64'(paddr), 64'h0);
        checkOutput("reset_pwdata_rdat", {pwdata, 24'h0, rdat}, 64'h0);
        rstn = 1'b1;

        $display("[TB] write 0x50 len 2, no stalls");
        stall_mode = 0; fixed_k = 0;
        preset = '{8'hA5, 8'h3C};
        run_cmd(1'b0, 7'h50, 4'd2, 1'b0, -1);

        $display("[TB] read 0x50 len 3, RXOCY 0,0,1 per byte");
        fixed_k = 2;
        preset = '{8'h11, 8'h22, 8'h33};
        run_cmd(1'b1, 7'h50, 4'd3, 1'b0, -1);

        $display("[TB] write with pready low 3 cycles per access");
        stall_mode = 3; fixed_k = 0;
        preset = '{8'hA5, 8'h3C};
        run_cmd(1'b0, 7'h50, 4'd2, 1'b0, -1);

        $display("[TB] TXOCY stuck full -> soft reset");
        stall_mode = 0; txocy_stuck = 1'b1;
        run_cmd(1'b0, 7'h2B, 4'd4, 1'b1, -1);
        txocy_stuck = 1'b0;

        $display("[TB] zero-length command");
        run_cmd(1'b0, 7'h11, 4'd0, 1'b0, 2);

        $display("[TB] randomized transfers");
        stall_mode = -1; fixed_k = -1;
        for (int n = 0; n < 8; n++)
            run_cmd(1'($urandom_range(0, 1)), 7'($urandom), 4'($urandom_range(1, 15)), 1'b0, -1);

        $display("[TB] reset during RXFIFO read");
        stall_mode = 2; fixed_k = 1;
        prep(1'b1, 7'h33, 4'd4, 1'b0);
        applyStimulus(1'b1, 7'h33, 4'd4);
        found = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            if (psel && paddr == BASE_A + 32'h10C) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checkOutput("reach_rdata", 64'(found), 64'h1);
        cmd_valid = 1'b0;
        rstn = 1'b0;
        #1;
        checkOutput("midreset_ctrl", {psel, penable, pwrite, done, err, rdat_valid, wdat_ready, cmd_ready}, 8'h01);
        checkOutput("midreset_paddr", 64'(paddr), 64'h0);
        checkOutput("midreset_pwdata_rdat", {pwdata, 24'h0, rdat}, 64'h0);
        @(negedge clk);
        rstn = 1'b1;
        n_access = 0;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (psel || done) found = 1'b1;
        end
        checkOutput("quiet_after_reset", 64'(found), 64'h0);
        checkOutput("idle_after_reset", 64'(cmd_ready), 64'h1);

        $display("[TB] transfer after reset");
        stall_mode = -1; fixed_k = -1;
        run_cmd(1'b0, 7'h6C, 4'd3, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
